// File: rtl/core_types_pkg.sv
// Shared core-wide sizing constants for branch-prediction structures.
package core_types_pkg;
    localparam int RAS_ENTRIES      = 8;
    localparam int RAS_TARGET_WIDTH = 31;
    localparam int LOG_RAS_ENTRIES  = $clog2(RAS_ENTRIES);
endpackage

// File: rtl/ras.sv
// Return address stack: circular flop array with checkpoint restore.
// Overflow overwrites the oldest entry; restore never rewrites entries.
module ras #(
    parameter int RAS_ENTRIES      = core_types_pkg::RAS_ENTRIES,
    parameter int RAS_TARGET_WIDTH = core_types_pkg::RAS_TARGET_WIDTH,
    localparam int LW = $clog2(RAS_ENTRIES),
    localparam int CW = LW + 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        link_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] link_pc,
    input  logic                        ret_valid,
    output logic [RAS_TARGET_WIDTH-1:0] ret_target,
    output logic                        ret_target_valid,
    output logic [LW-1:0]               ras_index,
    output logic [CW-1:0]               ras_count,
    input  logic                        update_valid,
    input  logic [LW-1:0]               update_ras_index,
    input  logic [CW-1:0]               update_count
);
    localparam logic [CW-1:0] FULL = CW'(RAS_ENTRIES);

    logic [RAS_TARGET_WIDTH-1:0] entry_q [RAS_ENTRIES];
    logic [LW-1:0]               ptr_q, ptr_d, top_idx, wr_idx;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        wr_en;

    assign top_idx          = ptr_q - 1'b1;
    assign ret_target       = entry_q[top_idx];
    assign ret_target_valid = (cnt_q != '0);
    assign ras_index        = ptr_q;
    assign ras_count        = cnt_q;

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (update_valid) begin
            ptr_d = update_ras_index;
            cnt_d = (update_count > FULL) ? FULL : update_count;
        end else if (link_valid && ret_valid) begin
            // Return immediately followed by a call: replace top in place.
            wr_en  = 1'b1;
            wr_idx = top_idx;
            if (cnt_q == '0) cnt_d = CW'(1);
        end else if (link_valid) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + 1'b1;
            cnt_d = (cnt_q == FULL) ? FULL : cnt_q + 1'b1;
        end else if (ret_valid) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_ENTRIES; i++) entry_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (wr_en) entry_q[wr_idx] <= link_pc;
        end
    end
endmodule

// File: tb/tb_ras.sv
// Randomized scoreboard bench for the return address stack.
module tb_ras;
    localparam int N = 8;
    localparam int W = 31;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         link_valid = 1'b0;
    logic [W-1:0] link_pc = '0;
    logic         ret_valid = 1'b0;
    logic [W-1:0] ret_target;
    logic         ret_target_valid;
    logic [2:0]   ras_index;
    logic [3:0]   ras_count;
    logic         update_valid = 1'b0;
    logic [2:0]   update_ras_index = '0;
    logic [3:0]   update_count = '0;

    ras #(.RAS_ENTRIES(N), .RAS_TARGET_WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .link_valid(link_valid), .link_pc(link_pc),
        .ret_valid(ret_valid), .ret_target(ret_target),
        .ret_target_valid(ret_target_valid), .ras_index(ras_index),
        .ras_count(ras_count), .update_valid(update_valid),
        .update_ras_index(update_ras_index), .update_count(update_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] tgt;
        logic         vld;
        logic [2:0]   idx;
        logic [3:0]   cnt;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           failures = 0;

    // Reference model: an ordinary array with integer pointer arithmetic.
    logic [W-1:0] m_ent [N];
    int           m_ptr = 0;
    int           m_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit rst, input bit lv, input logic [W-1:0] pc,
                         input bit rv, input bit uv, input int ui, input int uc);
        if (rst) begin
            m_ptr = 0; m_cnt = 0;
            for (int i = 0; i < N; i++) m_ent[i] = '0;
        end else if (uv) begin
            m_ptr = ui;
            m_cnt = (uc > N) ? N : uc;
        end else if (lv && rv) begin
            m_ent[(m_ptr + N - 1) % N] = pc;
            if (m_cnt == 0) m_cnt = 1;
        end else if (lv) begin
            m_ent[m_ptr] = pc;
            m_ptr = (m_ptr + 1) % N;
            m_cnt = (m_cnt + 1 > N) ? N : m_cnt + 1;
        end else if (rv) begin
            m_ptr = (m_ptr + N - 1) % N;
            m_cnt = (m_cnt == 0) ? 0 : m_cnt - 1;
        end
    endtask

    task automatic step(input bit rst, input bit lv, input logic [W-1:0] pc,
                        input bit rv, input bit uv, input int ui, input int uc);
        exp_t e;
        RST = rst; link_valid = lv; link_pc = pc; ret_valid = rv;
        update_valid = uv; update_ras_index = 3'(ui); update_count = 4'(uc);
        @(posedge CLK);
        model(rst, lv, pc, rv, uv, ui, uc);
        e.tgt = m_ent[(m_ptr + N - 1) % N];
        e.vld = (m_cnt != 0);
        e.idx = 3'(m_ptr);
        e.cnt = 4'(m_cnt);
        sb.push_back(e);
        #1;
        RST = 0; link_valid = 0; ret_valid = 0; update_valid = 0;
    endtask

    task automatic push(input logic [W-1:0] pc); step(0, 1, pc, 0, 0, 0, 0); endtask
    task automatic pop();                        step(0, 0, '0, 1, 0, 0, 0); endtask
    task automatic rst_cyc();                    step(1, 0, '0, 0, 0, 0, 0); endtask

    // Monitor: outputs are state-only, so every negedge presents one result.
    always @(negedge CLK) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("ret_target", 64'(ret_target), 64'(e.tgt));
            chk("ret_target_valid", 64'(ret_target_valid), 64'(e.vld));
            chk("ras_index", 64'(ras_index), 64'(e.idx));
            chk("ras_count", 64'(ras_count), 64'(e.cnt));
        end
    end

    initial begin
        int ck_i, ck_c, r, guard;
        // Reset and basic pushes
        rst_cyc();
        chk("reset_count", 64'(ras_count), 64'd0);
        push(31'h100); push(31'h200); push(31'h300);
        chk("push3_target", 64'(ret_target), 64'h300);
        chk("push3_count", 64'(ras_count), 64'd3);
        chk("push3_index", 64'(ras_index), 64'd3);

        // Overflow then drain
        rst_cyc();
        for (int i = 1; i <= 9; i++) push(31'(i));
        chk("ovf_count", 64'(ras_count), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk("drain_target", 64'(ret_target), 64'(9 - i));
            pop();
        end
        chk("drain_count", 64'(ras_count), 64'd0);
        chk("drain_valid", 64'(ret_target_valid), 64'd0);

        // Simultaneous push and pop
        rst_cyc();
        push(31'h10);
        step(0, 1, 31'h20, 1, 0, 0, 0);
        chk("pp_target", 64'(ret_target), 64'h20);
        chk("pp_count", 64'(ras_count), 64'd1);
        chk("pp_index", 64'(ras_index), 64'd1);

        // Checkpoint restore overrides a same-cycle push
        rst_cyc();
        push(31'h1); push(31'h2);
        ck_i = int'(ras_index); ck_c = int'(ras_count);
        push(31'hA); pop(); pop();
        step(0, 1, 31'h77, 0, 1, ck_i, ck_c);
        chk("restore_index", 64'(ras_index), 64'd2);
        chk("restore_count", 64'(ras_count), 64'd2);
        chk("restore_target", 64'(ret_target), 64'h2);
        step(0, 0, '0, 0, 1, 5, 13);
        chk("restore_clamp", 64'(ras_count), 64'd8);

        // Pop on empty
        rst_cyc();
        pop();
        chk("empty_pop_index", 64'(ras_index), 64'd7);
        chk("empty_pop_count", 64'(ras_count), 64'd0);
        chk("empty_pop_valid", 64'(ret_target_valid), 64'd0);
        push(31'h55);
        chk("empty_push_count", 64'(ras_count), 64'd1);

        // Reset beats concurrent push and update
        rst_cyc();
        for (int i = 0; i < 5; i++) push(31'(i + 40));
        step(1, 1, 31'h99, 0, 1, 3, 4);
        chk("rst_prio_count", 64'(ras_count), 64'd0);
        chk("rst_prio_target", 64'(ret_target), 64'd0);
        chk("rst_prio_index", 64'(ras_index), 64'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            step(r == 0, $urandom_range(0, 2) != 0, 31'($urandom), $urandom_range(0, 2) == 0,
                 r < 6, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
        end

        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(posedge CLK);
            guard++;
        end
        @(posedge CLK);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ras.md
RAS -- requirements
Module: ras

Interface
REQ-001 The module SHALL take parameter RAS_ENTRIES, default 8, meaning the stack depth (a power of two, at least 2).
REQ-002 The module SHALL take parameter RAS_TARGET_WIDTH, default 31, meaning the return PC width with PC[0] dropped.
REQ-003 The module SHALL have port CLK  input  1  the single clock, with every register updating on its rising edge.
REQ-004 The module SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 The module SHALL have port link_valid  input  1  push request from a predicted call.
REQ-006 The module SHALL have port link_pc  input  RAS_TARGET_WIDTH  the return address to push.
REQ-007 The module SHALL have port ret_valid  input  1  pop request from a predicted return.
REQ-008 The module SHALL have port ret_target  output  RAS_TARGET_WIDTH  the current top-of-stack entry.
REQ-009 The module SHALL have port ret_target_valid  output  1  asserted when the stack is non-empty.
REQ-010 The module SHALL have port ras_index  output  log2(RAS_ENTRIES)  the current stack pointer, used as a checkpoint.
REQ-011 The module SHALL have port ras_count  output  log2(RAS_ENTRIES)+1  the current occupancy, used as a checkpoint.
REQ-012 The module SHALL have port update_valid  input  1  mispredict restore request.
REQ-013 The module SHALL have ports update_ras_index and update_count, both inputs, with the same widths as ras_index and ras_count, giving the checkpoint to restore.

Function
REQ-014 The stack SHALL be a circular array; ptr SHALL point at the next free slot and the top SHALL be entry[ptr-1], computed mod RAS_ENTRIES.
REQ-015 ret_target SHALL equal entry[ptr-1] combinationally from registered state, with zero added latency.
REQ-016 ret_target_valid SHALL equal (count != 0).
REQ-017 ras_index and ras_count SHALL show the pre-edge ptr and count.
REQ-018 A push alone SHALL write entry[ptr] <= link_pc, set ptr <= ptr+1 (wrapping), and set count <= min(count+1, RAS_ENTRIES).
REQ-019 Overflow SHALL silently overwrite the oldest entry, with count saturating at RAS_ENTRIES.
REQ-020 A pop alone SHALL set ptr <= ptr-1 (wrapping) and count <= max(count-1, 0); entries SHALL be left unchanged.
REQ-021 A pop on an empty stack SHALL still decrement ptr, keep count 0 and keep ret_target_valid low.
REQ-022 A simultaneous push and pop SHALL write entry[ptr-1] <= link_pc with ptr unchanged.
REQ-023 For a simultaneous push and pop, count SHALL be unchanged if non-zero, else set to 1.
REQ-024 update_valid SHALL set ptr <= update_ras_index and count <= update_count, and SHALL override any push or pop in the same cycle.
REQ-025 A restore SHALL NOT rewrite any entry, so corruption by wrong-path pushes is accepted.
REQ-026 update_count values greater than RAS_ENTRIES SHALL be clamped to RAS_ENTRIES.
REQ-027 The module SHALL have no internal stall or backpressure; every request SHALL complete in one cycle.

Reset
REQ-028 While RST is high at a clock edge, ptr, count and all entries SHALL be set to 0.
REQ-029 Reset SHALL take priority over update, push and pop.
REQ-030 Out of reset, outputs SHALL be ret_target=0, ret_target_valid=0, ras_index=0 and ras_count=0.
REQ-031 Reset asserted mid-sequence SHALL discard all stack contents at the next edge.

Structure
REQ-032 RAS_ENTRIES, RAS_TARGET_WIDTH and a new LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES) SHALL live in core_types_pkg.
REQ-033 The module SHALL be a single flat module with no sub-modules; the entry array SHALL be flops.

Verification
REQ-034 Reset, then push 0x100, 0x200, 0x300 -> ret_target=0x300, ras_count=3, ras_index=3.
REQ-035 Push 9 values 1..9, then pop 8 times -> returns 9,8,...,2; count reaches 0 and ret_target_valid=0.
REQ-036 Push 0x10, then push and pop together with 0x20 -> ret_target=0x20, count=1, ptr unchanged.
REQ-037 Checkpoint (index 2, count 2), push 0xA, pop twice, then update_valid with a push in the same cycle -> ptr=2, count=2, push ignored.
REQ-038 Pop on empty stack -> ras_index goes 0->7, count stays 0, ret_target_valid=0; the next push makes count=1.
REQ-039 Assert RST with count=5 -> all outputs are 0 the next cycle, regardless of a concurrent push or update.
